// File: rtl/seq_divider_if.sv
// Start/done handshake and result bus of the sequential 8-bit divider.
// The master side issues operands and start; the slave side returns status and results.
interface seq_divider_if;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential 8-bit restoring divider: one quotient bit per clock, start/done handshake.
// Optional macro DIV_SIGNED_EN selects two's-complement operands with truncating sign fixup.
module seq_divider (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] neg8(input logic [7:0] v);
        return (~v) + 8'd1;
    endfunction

    state_t     state_r;
    state_t     state_s;

    logic       accept_s;
    logic       zero_div_s;
    logic       last_s;
    logic       res_load_s;
    logic       zero_load_s;

    logic [7:0] dvd_abs_s;
    logic [7:0] dvs_abs_s;
    logic [7:0] dvd_r;
    logic [7:0] dvs_r;
    logic [8:0] rem_r;
    logic [7:0] q_work_r;
    logic [2:0] k_r;

    logic [8:0] shift_s;
    logic [8:0] trial_s;
    logic [8:0] rem_next_s;
    logic [7:0] q_next_s;
    logic [7:0] q_fix_s;
    logic [7:0] r_fix_s;

    logic       busy_s;
    logic       done_s;
    logic       busy_r;
    logic       done_r;
    logic [7:0] quotient_r;
    logic [7:0] remainder_r;
    logic       dbz_r;

`ifdef DIV_SIGNED_EN
    logic       neg_q_r;
    logic       neg_r_r;

    // Magnitudes feed the unsigned iteration; -128 maps to 8'h80, which is its magnitude.
    assign dvd_abs_s = bus.dividend[7] ? neg8(bus.dividend) : bus.dividend;
    assign dvs_abs_s = bus.divisor[7]  ? neg8(bus.divisor)  : bus.divisor;
`else
    assign dvd_abs_s = bus.dividend;
    assign dvs_abs_s = bus.divisor;
`endif

    // A start is honoured everywhere except while iterating.
    assign accept_s    = bus.start && (state_r != ST_RUN);
    assign zero_div_s  = (bus.divisor == 8'd0);
    assign last_s      = (k_r == 3'd0);
    assign res_load_s  = (state_r == ST_RUN) && last_s;
    assign zero_load_s = accept_s && zero_div_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_s = zero_div_s ? ST_DONE : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // One restoring step: shift in dividend bit k and keep the trial difference if it did not borrow.
    always_comb begin
        shift_s    = {rem_r[7:0], dvd_r[k_r]};
        trial_s    = shift_s - {1'b0, dvs_r};
        rem_next_s = trial_s[8] ? shift_s : trial_s;
        q_next_s   = q_work_r;
        q_next_s[k_r] = ~trial_s[8];
    end

    // Final result with sign fixup applied on the way into DONE so latency is unchanged.
    always_comb begin
        q_fix_s = q_next_s;
        r_fix_s = rem_next_s[7:0];
`ifdef DIV_SIGNED_EN
        if (neg_q_r) begin
            q_fix_s = neg8(q_next_s);
        end else begin
            q_fix_s = q_next_s;
        end
        if (neg_r_r) begin
            r_fix_s = neg8(rem_next_s[7:0]);
        end else begin
            r_fix_s = rem_next_s[7:0];
        end
`endif
    end

    // Output decode, registered one stage below so the ports come straight from flops.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            ST_RUN:  busy_s = 1'b1;
            ST_DONE: done_s = 1'b1;
            ST_IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Operand capture and iteration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_r    <= 8'd0;
            dvs_r    <= 8'd0;
            rem_r    <= 9'd0;
            q_work_r <= 8'd0;
            k_r      <= 3'd0;
`ifdef DIV_SIGNED_EN
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
`endif
        end else if (accept_s) begin
            dvd_r    <= dvd_abs_s;
            dvs_r    <= dvs_abs_s;
            rem_r    <= 9'd0;
            q_work_r <= 8'd0;
            k_r      <= 3'd7;
`ifdef DIV_SIGNED_EN
            neg_q_r  <= bus.dividend[7] ^ bus.divisor[7];
            neg_r_r  <= bus.dividend[7];
`endif
        end else if (state_r == ST_RUN) begin
            rem_r    <= rem_next_s;
            q_work_r <= q_next_s;
            k_r      <= k_r - 3'd1;
        end
    end

    // Status and result registers; results and the zero flag change only on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= 8'd0;
            remainder_r <= 8'd0;
            dbz_r       <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
            if (zero_load_s) begin
                quotient_r  <= 8'hFF;
                remainder_r <= bus.dividend;
                dbz_r       <= 1'b1;
            end else if (res_load_s) begin
                quotient_r  <= q_fix_s;
                remainder_r <= r_fix_s;
                dbz_r       <= 1'b0;
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: cycle-level arithmetic reference model, per-cycle compare,
// directed handshake/boundary cases and randomized traffic.
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_divider_if bus ();

    seq_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference quotient/remainder straight from integer division.
    function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [7:0] b);
`ifdef DIV_SIGNED_EN
        int sa, sb, q;
        sa = int'($signed(a));
        sb = int'($signed(b));
        q = sa / sb;
        return q[7:0];
`else
        return a / b;
`endif
    endfunction

    function automatic logic [7:0] ref_r(input logic [7:0] a, input logic [7:0] b);
`ifdef DIV_SIGNED_EN
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = sa % sb;
        return r[7:0];
`else
        return a % b;
`endif
    endfunction

    // Behavioural model: a busy-cycle countdown and the pending arithmetic result.
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_z = 1'b0;
    logic [7:0] m_q = 8'd0;
    logic [7:0] m_r = 8'd0;
    logic [7:0] p_q = 8'd0;
    logic [7:0] p_r = 8'd0;
    int         m_left = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_q    <= 8'd0;
            m_r    <= 8'd0;
            m_z    <= 1'b0;
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_busy <= (m_left > 1);
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_q <= p_q;
                m_r <= p_r;
                m_z <= 1'b0;
            end
        end else begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            if (bus.start) begin
                if (bus.divisor == 8'd0) begin
                    m_done <= 1'b1;
                    m_q    <= 8'hFF;
                    m_r    <= bus.dividend;
                    m_z    <= 1'b1;
                end else begin
                    m_busy <= 1'b1;
                    m_left <= 8;
                    p_q    <= ref_q(bus.dividend, bus.divisor);
                    p_r    <= ref_r(bus.dividend, bus.divisor);
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", bus.busy, m_busy);
            chk("cyc_done", bus.done, m_done);
            chk("cyc_quotient", bus.quotient, m_q);
            chk("cyc_remainder", bus.remainder, m_r);
            chk("cyc_div_by_zero", bus.div_by_zero, m_z);
            chk("cyc_busy_done_excl", bus.busy & bus.done, 1'b0);
        end
    end

    // Issue one operation, optionally poke a start at cycle T+poke, wait for done, check literals.
    task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic ez,
                          input int elat, input bit now, input int poke,
                          input logic [7:0] pa, input logic [7:0] pb);
        int lat;
        bit seen_busy;
        if (!now) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        lat = 0;
        seen_busy = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            bus.start = (lat == poke);
            if (lat == poke) begin
                bus.dividend = pa;
                bus.divisor  = pb;
            end
            seen_busy |= bus.busy;
        end while (bus.done !== 1'b1 && lat < 30);
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_quotient"}, bus.quotient, eq);
        chk({nm, "_remainder"}, bus.remainder, er);
        chk({nm, "_div_by_zero"}, bus.div_by_zero, ez);
        chk({nm, "_busy_seen"}, seen_busy, (elat > 1));
    endtask

    initial begin
        int dones;
        bus.start    = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor  = 8'd0;
        rst_n        = 1'b0;

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_quotient", bus.quotient, 8'h00);
        chk("rst_remainder", bus.remainder, 8'h00);
        chk("rst_div_by_zero", bus.div_by_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pin the reference model with hand-computed values.
        chk("model_100_7_q", ref_q(8'd100, 8'd7), 8'd14);
        chk("model_100_7_r", ref_r(8'd100, 8'd7), 8'd2);
        chk("model_50_5_q", ref_q(8'd50, 8'd5), 8'd10);

        run_op("div_100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 1'b0, 0, 8'd0, 8'd0);
        run_op("div_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, 1'b0, 0, 8'd0, 8'd0);
        run_op("div_3_200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 9, 1'b0, 0, 8'd0, 8'd0);
        run_op("div_200_200", 8'd200, 8'd200, 8'd1, 8'd0, 1'b0, 9, 1'b0, 0, 8'd0, 8'd0);
        run_op("div_5_0", 8'd5, 8'd0, 8'hFF, 8'h05, 1'b1, 1, 1'b0, 0, 8'd0, 8'd0);
        run_op("ignored_start", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 1'b0, 4, 8'd50, 8'd5);
        run_op("first_of_pair", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 1'b0, 0, 8'd0, 8'd0);
        run_op("back_to_back", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 9, 1'b1, 0, 8'd0, 8'd0);
`ifdef DIV_SIGNED_EN
        run_op("s_m7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 9, 1'b0, 0, 8'd0, 8'd0);
        run_op("s_7_m2", 8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0, 9, 1'b0, 0, 8'd0, 8'd0);
        run_op("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9, 1'b0, 0, 8'd0, 8'd0);
`endif

        // Reset in the middle of a division.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_quotient", bus.quotient, 8'h00);
        chk("midrst_remainder", bus.remainder, 8'h00);
        rst_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        chk("midrst_no_done", dones, 0);

        // Randomized traffic: starts at any time, zero divisors, occasional resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n        = ($urandom_range(0, 299) != 0);
            bus.start    = ($urandom_range(0, 2) == 0);
            bus.dividend = 8'($urandom);
            bus.divisor  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        end
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
